// File: rtl/pc_sequenciador.sv
// pc_sequenciador: registered program-counter sequencer for the CatCORE fetch
// stage. Selects the next PC from sequential, conditional branch, absolute,
// register-indirect, call and return modes. Owns a LIFO return-address stack
// with occupancy count and sticky overflow/underflow flags. All outputs come
// straight from registers.
module pc_sequenciador #(
  parameter int unsigned              WIDTH        = 32,
  parameter int unsigned              INCREMENTO   = 1,
  parameter logic [WIDTH-1:0]         RESET_VECTOR = '0,
  parameter int unsigned              PROFUNDIDADE = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  habilita,
  input  logic [2:0]                            controle,
  input  logic                                  sinal_ZERO,
  input  logic [WIDTH-1:0]                      imediato_extendido,
  input  logic [WIDTH-1:0]                      absoluto_jump,
  input  logic [WIDTH-1:0]                      register_jump,
  output logic [WIDTH-1:0]                      PC,
  output logic [$clog2(PROFUNDIDADE+1)-1:0]     nivel_pilha,
  output logic                                  erro_overflow,
  output logic                                  erro_underflow
);

  // Occupancy counter width (0..PROFUNDIDADE) and stack index width.
  localparam int unsigned NW = $clog2(PROFUNDIDADE + 1);
  localparam int unsigned IW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  // Next-PC mode encoding.
  typedef enum logic [2:0] {
    MODO_SEQ     = 3'b000,
    MODO_BEQ     = 3'b001,
    MODO_BNE     = 3'b010,
    MODO_JUMP    = 3'b011,
    MODO_JREG    = 3'b100,
    MODO_CALL    = 3'b101,
    MODO_RET     = 3'b110,
    MODO_HOLD    = 3'b111
  } modo_e;

  // Architectural state.
  logic [WIDTH-1:0] pc_q,       pc_d;
  logic [NW-1:0]    nivel_q,    nivel_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  // Return-address storage; entries at or above nivel_q are don't-care.
  logic [WIDTH-1:0] pilha_q [0:PROFUNDIDADE-1];

  // Combinational helpers.
  logic [WIDTH-1:0] seq_s;
  logic             pilha_cheia_s;
  logic             pilha_vazia_s;
  logic [IW-1:0]    idx_push_s;
  logic [IW-1:0]    idx_topo_s;
  logic             push_s;
  modo_e            modo_s;

  assign modo_s        = modo_e'(controle);
  assign seq_s         = pc_q + WIDTH'(INCREMENTO);
  assign pilha_cheia_s = (nivel_q == NW'(PROFUNDIDADE));
  assign pilha_vazia_s = (nivel_q == NW'(0));
  // Push slot is the first free entry; top is the last valid one. Both are
  // only used when the corresponding full/empty guard allows it.
  assign idx_push_s    = IW'(nivel_q);
  assign idx_topo_s    = IW'(nivel_q - NW'(1));

  // Next-state selection for PC, stack level and error flags.
  always_comb begin
    pc_d        = pc_q;
    nivel_d     = nivel_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_s      = 1'b0;
    if (habilita == 1'b1) begin
      case (modo_s)
        MODO_SEQ: begin
          pc_d = seq_s;
        end
        MODO_BEQ: begin
          if (sinal_ZERO == 1'b1) begin
            pc_d = imediato_extendido;
          end else begin
            pc_d = seq_s;
          end
        end
        MODO_BNE: begin
          if (sinal_ZERO == 1'b0) begin
            pc_d = imediato_extendido;
          end else begin
            pc_d = seq_s;
          end
        end
        MODO_JUMP: begin
          pc_d = absoluto_jump;
        end
        MODO_JREG: begin
          pc_d = register_jump;
        end
        MODO_CALL: begin
          // The jump is always taken; only the push depends on free space.
          pc_d = absoluto_jump;
          if (pilha_cheia_s) begin
            overflow_d = 1'b1;
          end else begin
            push_s  = reset;
            nivel_d = nivel_q + NW'(1);
          end
        end
        MODO_RET: begin
          // An empty stack falls through to the sequential address.
          if (pilha_vazia_s) begin
            pc_d        = seq_s;
            underflow_d = 1'b1;
          end else begin
            pc_d    = pilha_q[idx_topo_s];
            nivel_d = nivel_q - NW'(1);
          end
        end
        MODO_HOLD: begin
          pc_d = pc_q;
        end
        default: begin
          pc_d = pc_q;
        end
      endcase
    end else begin
      pc_d = pc_q;
    end
  end

  // Architectural registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (reset == 1'b0) begin
      pc_q        <= RESET_VECTOR;
      nivel_q     <= NW'(0);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      nivel_q     <= nivel_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Return-address write; push_s is already suppressed during reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      pilha_q[idx_push_s] <= seq_s;
    end
  end

  assign PC             = pc_q;
  assign nivel_pilha    = nivel_q;
  assign erro_overflow  = overflow_q;
  assign erro_underflow = underflow_q;

endmodule

// File: tb/tb_pc_sequenciador.sv
// Self-checking bench for pc_sequenciador: directed scenarios against constant
// expectations plus a randomized run against a queue-based reference model.
module tb_pc_sequenciador;

  localparam int unsigned W  = 32;
  localparam int unsigned P  = 4;
  localparam int unsigned NW = $clog2(P + 1);

  logic          clock;
  logic          reset;
  logic          habilita;
  logic [2:0]    controle;
  logic          sinal_ZERO;
  logic [W-1:0]  imediato_extendido;
  logic [W-1:0]  absoluto_jump;
  logic [W-1:0]  register_jump;
  logic [W-1:0]  PC;
  logic [NW-1:0] nivel_pilha;
  logic          erro_overflow;
  logic          erro_underflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] pc_m;
  logic [W-1:0] pilha_m [$];
  logic         ovf_m;
  logic         unf_m;

  pc_sequenciador #(
    .WIDTH(W), .INCREMENTO(1), .RESET_VECTOR(32'h0), .PROFUNDIDADE(P)
  ) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .controle(controle),
    .sinal_ZERO(sinal_ZERO), .imediato_extendido(imediato_extendido),
    .absoluto_jump(absoluto_jump), .register_jump(register_jump),
    .PC(PC), .nivel_pilha(nivel_pilha),
    .erro_overflow(erro_overflow), .erro_underflow(erro_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs, advance the model, then wait past the edge.
  task automatic apply(input logic rst, input logic hab, input logic [2:0] ctl,
                       input logic z, input logic [W-1:0] imm,
                       input logic [W-1:0] absj, input logic [W-1:0] regj);
    logic [W-1:0] seq;
    reset = rst; habilita = hab; controle = ctl; sinal_ZERO = z;
    imediato_extendido = imm; absoluto_jump = absj; register_jump = regj;
    seq = pc_m + 32'd1;
    if (!rst) begin
      pc_m = 32'h0; pilha_m.delete(); ovf_m = 1'b0; unf_m = 1'b0;
    end else if (hab) begin
      if (ctl == 3'd0) pc_m = seq;
      else if (ctl == 3'd1) pc_m = z ? imm : seq;
      else if (ctl == 3'd2) pc_m = z ? seq : imm;
      else if (ctl == 3'd3) pc_m = absj;
      else if (ctl == 3'd4) pc_m = regj;
      else if (ctl == 3'd5) begin
        if (pilha_m.size() >= P) ovf_m = 1'b1;
        else pilha_m.push_back(seq);
        pc_m = absj;
      end else if (ctl == 3'd6) begin
        if (pilha_m.size() == 0) begin pc_m = seq; unf_m = 1'b1; end
        else pc_m = pilha_m.pop_back();
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    apply(1'b0, 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
    checks++; if (nivel_pilha !== 3'd0) begin errors++; $display("FAIL reset_nivel: got %0d want 0", nivel_pilha); end
    checks++; if ({erro_overflow, erro_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {erro_overflow, erro_underflow}); end
    for (int i = 1; i <= 3; i++) begin
      apply(1'b1, 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
      checks++; if (PC !== 32'(i)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, PC, 32'(i)); end
    end
  endtask

  task automatic test_branches();
    apply(1'b1, 1'b1, 3'd3, 1'b0, 32'h0, 32'h5, 32'h0);
    checks++; if (PC !== 32'h5) begin errors++; $display("FAIL jump_abs: got %h want %h", PC, 32'h5); end
    apply(1'b1, 1'b1, 3'd1, 1'b1, 32'h40, 32'h0, 32'h0);
    checks++; if (PC !== 32'h40) begin errors++; $display("FAIL beq_taken: got %h want %h", PC, 32'h40); end
    apply(1'b1, 1'b1, 3'd2, 1'b1, 32'h90, 32'h0, 32'h0);
    checks++; if (PC !== 32'h41) begin errors++; $display("FAIL bne_not_taken: got %h want %h", PC, 32'h41); end
    apply(1'b1, 1'b1, 3'd2, 1'b0, 32'h80, 32'h0, 32'h0);
    checks++; if (PC !== 32'h80) begin errors++; $display("FAIL bne_taken: got %h want %h", PC, 32'h80); end
    apply(1'b1, 1'b1, 3'd1, 1'b0, 32'h300, 32'h0, 32'h0);
    checks++; if (PC !== 32'h81) begin errors++; $display("FAIL beq_not_taken: got %h want %h", PC, 32'h81); end
    apply(1'b1, 1'b1, 3'd4, 1'b0, 32'h0, 32'h0, 32'h1234);
    checks++; if (PC !== 32'h1234) begin errors++; $display("FAIL jreg: got %h want %h", PC, 32'h1234); end
  endtask

  task automatic test_call_return();
    apply(1'b1, 1'b1, 3'd3, 1'b0, 32'h0, 32'h10, 32'h0);
    apply(1'b1, 1'b1, 3'd5, 1'b0, 32'h0, 32'h100, 32'h0);
    checks++; if (PC !== 32'h100 || nivel_pilha !== 3'd1) begin errors++; $display("FAIL call1: got pc=%h nivel=%0d want pc=100 nivel=1", PC, nivel_pilha); end
    apply(1'b1, 1'b1, 3'd5, 1'b0, 32'h0, 32'h200, 32'h0);
    checks++; if (PC !== 32'h200 || nivel_pilha !== 3'd2) begin errors++; $display("FAIL call2: got pc=%h nivel=%0d want pc=200 nivel=2", PC, nivel_pilha); end
    apply(1'b1, 1'b1, 3'd6, 1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (PC !== 32'h101 || nivel_pilha !== 3'd1) begin errors++; $display("FAIL ret1: got pc=%h nivel=%0d want pc=101 nivel=1", PC, nivel_pilha); end
    apply(1'b1, 1'b1, 3'd6, 1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (PC !== 32'h11 || nivel_pilha !== 3'd0) begin errors++; $display("FAIL ret2: got pc=%h nivel=%0d want pc=11 nivel=0", PC, nivel_pilha); end
    checks++; if ({erro_overflow, erro_underflow} !== 2'b00) begin errors++; $display("FAIL callret_flags: got %b want 00", {erro_overflow, erro_underflow}); end
  endtask

  task automatic test_overflow_underflow();
    logic [W-1:0] exp_ret [4];
    exp_ret[0] = 32'h1201; exp_ret[1] = 32'h1101; exp_ret[2] = 32'h1001; exp_ret[3] = 32'h1;
    apply(1'b0, 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b1, 3'd5, 1'b0, 32'h0, 32'h1000 + 32'(i) * 32'h100, 32'h0);
    end
    checks++; if (PC !== 32'h1400 || nivel_pilha !== 3'd4 || erro_overflow !== 1'b1) begin errors++; $display("FAIL overflow: got pc=%h nivel=%0d ovf=%b want pc=1400 nivel=4 ovf=1", PC, nivel_pilha, erro_overflow); end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b1, 3'd6, 1'b0, 32'h0, 32'h0, 32'h0);
      checks++; if (PC !== exp_ret[i] || nivel_pilha !== 3'(3 - i) || erro_underflow !== 1'b0) begin errors++; $display("FAIL pop%0d: got pc=%h nivel=%0d unf=%b want pc=%h nivel=%0d unf=0", i, PC, nivel_pilha, erro_underflow, exp_ret[i], 3 - i); end
    end
    apply(1'b1, 1'b1, 3'd6, 1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (PC !== 32'h2 || nivel_pilha !== 3'd0 || erro_underflow !== 1'b1) begin errors++; $display("FAIL underflow: got pc=%h nivel=%0d unf=%b want pc=2 nivel=0 unf=1", PC, nivel_pilha, erro_underflow); end
    apply(1'b1, 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    apply(1'b1, 1'b1, 3'd5, 1'b0, 32'h0, 32'h50, 32'h0);
    checks++; if ({erro_overflow, erro_underflow} !== 2'b11) begin errors++; $display("FAIL sticky_flags: got %b want 11", {erro_overflow, erro_underflow}); end
  endtask

  task automatic test_stall_hold_wrap();
    apply(1'b0, 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    apply(1'b1, 1'b1, 3'd3, 1'b0, 32'h0, 32'h20, 32'h0);
    apply(1'b1, 1'b0, 3'd5, 1'b0, 32'h0, 32'h300, 32'h0);
    checks++; if (PC !== 32'h20 || nivel_pilha !== 3'd0) begin errors++; $display("FAIL stall_call: got pc=%h nivel=%0d want pc=20 nivel=0", PC, nivel_pilha); end
    apply(1'b1, 1'b0, 3'd6, 1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (PC !== 32'h20 || erro_underflow !== 1'b0) begin errors++; $display("FAIL stall_ret: got pc=%h unf=%b want pc=20 unf=0", PC, erro_underflow); end
    apply(1'b1, 1'b1, 3'd7, 1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (PC !== 32'h20) begin errors++; $display("FAIL hold: got %h want %h", PC, 32'h20); end
    apply(1'b1, 1'b1, 3'd3, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0);
    apply(1'b1, 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap: got %h want %h", PC, 32'h0); end
  endtask

  task automatic test_reset_mid_op();
    apply(1'b0, 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    apply(1'b1, 1'b1, 3'd6, 1'b0, 32'h0, 32'h0, 32'h0);
    apply(1'b1, 1'b1, 3'd5, 1'b0, 32'h0, 32'h400, 32'h0);
    apply(1'b1, 1'b1, 3'd5, 1'b0, 32'h0, 32'h500, 32'h0);
    checks++; if (nivel_pilha !== 3'd2 || erro_underflow !== 1'b1) begin errors++; $display("FAIL pre_reset: got nivel=%0d unf=%b want nivel=2 unf=1", nivel_pilha, erro_underflow); end
    apply(1'b0, 1'b1, 3'd5, 1'b0, 32'h0, 32'h600, 32'h0);
    checks++; if (PC !== 32'h0 || nivel_pilha !== 3'd0 || {erro_overflow, erro_underflow} !== 2'b00) begin errors++; $display("FAIL reset_mid_call: got pc=%h nivel=%0d flags=%b want pc=0 nivel=0 flags=00", PC, nivel_pilha, {erro_overflow, erro_underflow}); end
    apply(1'b1, 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (PC !== 32'h1) begin errors++; $display("FAIL first_after_reset: got %h want %h", PC, 32'h1); end
  endtask

  task automatic test_random();
    logic rst, hab, z;
    logic [2:0] ctl;
    apply(1'b0, 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) >= 2);
      hab = ($urandom_range(0, 9) != 0);
      ctl = 3'($urandom_range(0, 7));
      z   = 1'($urandom_range(0, 1));
      apply(rst, hab, ctl, z, $urandom, $urandom, $urandom);
      checks++;
      if (PC !== pc_m || nivel_pilha !== 3'(pilha_m.size()) || erro_overflow !== ovf_m || erro_underflow !== unf_m) begin
        errors++;
        $display("FAIL random%0d: got pc=%h nivel=%0d ovf=%b unf=%b want pc=%h nivel=%0d ovf=%b unf=%b",
                 i, PC, nivel_pilha, erro_overflow, erro_underflow, pc_m, pilha_m.size(), ovf_m, unf_m);
      end
    end
  endtask

  initial begin
    reset = 1'b0; habilita = 1'b0; controle = 3'd0; sinal_ZERO = 1'b0;
    imediato_extendido = 32'h0; absoluto_jump = 32'h0; register_jump = 32'h0;
    pc_m = 32'h0; ovf_m = 1'b0; unf_m = 1'b0;
    #2;
    test_reset();
    test_branches();
    test_call_return();
    test_overflow_underflow();
    test_stall_hold_wrap();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
